// File: rtl/colorspace_pkg.sv
// Shared definitions for the colorspace stage: default geometry of the line
// buffer, subpixel width and a packed RGB pixel view used by neighbours.
package colorspace_pkg;

  localparam int COLUMNS_DEFAULT     = 640;
  localparam int ROWS_DEFAULT        = 3;
  localparam int PIXEL_DEPTH_DEFAULT = 24;
  localparam int SUBPIXEL_DEPTH      = PIXEL_DEPTH_DEFAULT / 3;

  // Packed pixel, red in the most significant third.
  typedef struct packed {
    logic [SUBPIXEL_DEPTH-1:0] r;
    logic [SUBPIXEL_DEPTH-1:0] g;
    logic [SUBPIXEL_DEPTH-1:0] b;
  } pixel_t;

  // Operation selected for a cycle once write priority has been applied.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } fb_op_e;

  // Reinterpret a flat word as a pixel struct.
  function automatic pixel_t to_pixel(input logic [PIXEL_DEPTH_DEFAULT-1:0] word);
    return pixel_t'(word);
  endfunction

  // Row-major linear index of a (column, row) location.
  function automatic int unsigned linear_index(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned columns);
    return row * columns + col;
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Plain word array with one write port and one registered read port.
// Kept free of reset and range logic so it can be swapped for an SRAM macro.
module frame_buffer_ram #(
  parameter int DEPTH  = 1920,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the word when strobed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  // Read port: load the addressed word, otherwise hold the last value.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Line buffer for the colorspace stage: P_ROWS lines of P_COLUMNS pixels,
// addressed by (column, row), with a one-cycle registered read result.
// Range checking, write-over-read priority and the reset-clearable output
// live here; storage is delegated to frame_buffer_ram.
module frame_buffer
  import colorspace_pkg::*;
#(
  parameter int P_COLUMNS     = COLUMNS_DEFAULT,
  parameter int P_ROWS        = ROWS_DEFAULT,
  parameter int P_PIXEL_DEPTH = PIXEL_DEPTH_DEFAULT
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic [$clog2(P_COLUMNS)-1:0] I_COLUMN,
  input  logic [$clog2(P_ROWS)-1:0]    I_ROW,
  input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
  input  logic                         I_WRITE_ENABLE,
  input  logic                         I_READ_ENABLE,
  output logic [P_PIXEL_DEPTH-1:0]     O_PIXEL
);

  localparam int COL_W  = $clog2(P_COLUMNS);
  localparam int ROW_W  = $clog2(P_ROWS);
  localparam int DEPTH  = P_ROWS * P_COLUMNS;
  localparam int ADDR_W = $clog2(DEPTH);

  // One extra bit so the limit itself is representable.
  localparam logic [COL_W:0] COL_LIMIT = (COL_W + 1)'(P_COLUMNS);
  localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W + 1)'(P_ROWS);

  logic                     in_range;
  logic [ADDR_W-1:0]        addr;
  fb_op_e                   op;
  logic                     ram_we;
  logic                     ram_re;
  logic [P_PIXEL_DEPTH-1:0] ram_rd_data;
  logic                     blank_p0;

  // Addresses past the last column or row never reach the array, so an
  // oversized column cannot alias into the next row.
  assign in_range = ({1'b0, I_COLUMN} < COL_LIMIT) && ({1'b0, I_ROW} < ROW_LIMIT);
  assign addr     = ADDR_W'(I_ROW) * ADDR_W'(P_COLUMNS) + ADDR_W'(I_COLUMN);

  // Resolve the cycle's operation: a write always wins over a read.
  always_comb begin
    op = OP_IDLE;
    if (I_WRITE_ENABLE) begin
      op = OP_WRITE;
    end else if (I_READ_ENABLE) begin
      op = OP_READ;
    end
  end

  // Nothing touches the array while reset is held.
  assign ram_we = (op == OP_WRITE) && in_range && I_RESET;
  assign ram_re = (op == OP_READ)  && in_range && I_RESET;

  frame_buffer_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (P_PIXEL_DEPTH)
  ) u_ram (
    .clk     (I_CLK),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (addr),
    .wr_data (I_PIXEL),
    .rd_data (ram_rd_data)
  );

  // ---- read stage p0: blanking flag tracks whether the output shows zero ----
  // Reset blanks immediately; a read reloads it (in range shows array data,
  // out of range shows zero); any other cycle holds it together with the
  // array's read register, so O_PIXEL holds as well.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      blank_p0 <= 1'b1;
    end else if (op == OP_READ) begin
      blank_p0 <= !in_range;
    end
  end

  assign O_PIXEL = blank_p0 ? '0 : ram_rd_data;

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: directed scenarios followed by randomized traffic
// checked against an array-based model of the pixel store.
module tb_frame_buffer;
  import colorspace_pkg::*;

  localparam int COLS = 640;
  localparam int ROWS = 3;

  logic        I_CLK;
  logic        I_RESET;
  logic [9:0]  I_COLUMN;
  logic [1:0]  I_ROW;
  logic [23:0] I_PIXEL;
  logic        I_WRITE_ENABLE;
  logic        I_READ_ENABLE;
  logic [23:0] O_PIXEL;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: stored pixels and the value O_PIXEL should show.
  logic [23:0] mdl_mem [ROWS][COLS];
  logic [23:0] mdl_out;

  frame_buffer #(
    .P_COLUMNS     (COLS),
    .P_ROWS        (ROWS),
    .P_PIXEL_DEPTH (24)
  ) dut (
    .I_CLK          (I_CLK),
    .I_RESET        (I_RESET),
    .I_COLUMN       (I_COLUMN),
    .I_ROW          (I_ROW),
    .I_PIXEL        (I_PIXEL),
    .I_WRITE_ENABLE (I_WRITE_ENABLE),
    .I_READ_ENABLE  (I_READ_ENABLE),
    .O_PIXEL        (O_PIXEL)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Apply one cycle of stimulus and advance the model over the rising edge.
  task automatic drive(input bit we, input bit re, input int col, input int row,
                       input logic [23:0] pix);
    bit inr;
    @(negedge I_CLK);
    I_WRITE_ENABLE = we;
    I_READ_ENABLE  = re;
    I_COLUMN       = 10'(col);
    I_ROW          = 2'(row);
    I_PIXEL        = pix;
    inr = (col < COLS) && (row < ROWS);
    @(posedge I_CLK);
    if (!I_RESET) begin
      mdl_out = '0;
    end else if (we) begin
      if (inr) mdl_mem[row][col] = pix;
    end else if (re) begin
      mdl_out = inr ? mdl_mem[row][col] : '0;
    end
    #1;
  endtask

  task automatic test_reset();
    I_RESET = 1'b1;
    I_WRITE_ENABLE = 1'b0;
    I_READ_ENABLE  = 1'b0;
    I_COLUMN = '0;
    I_ROW    = '0;
    I_PIXEL  = '0;
    mdl_out  = '0;
    #2 I_RESET = 1'b0;
    #1;
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_assert: got %h want 000000", O_PIXEL);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge I_CLK); #1;
      n_cmp++;
      if (O_PIXEL !== 24'h000000) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got %h want 000000", i, O_PIXEL);
      end
    end
    @(negedge I_CLK);
    I_RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 24'h0);
      n_cmp++;
      if (O_PIXEL !== 24'h000000) begin
        n_fail++;
        $display("FAIL reset_idle%0d: got %h want 000000", i, O_PIXEL);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1, 0, 0, 0, 24'hFFFFFF);
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL wr_no_change: got %h want 000000", O_PIXEL);
    end
    drive(0, 1, 0, 0, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL rd_00: got %h want FFFFFF", O_PIXEL);
    end
    drive(0, 0, 0, 0, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL rd_hold: got %h want FFFFFF", O_PIXEL);
    end
  endtask

  task automatic test_corners();
    drive(1, 0, 639, 2, 24'hFF0000);
    drive(0, 1, 639, 2, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFF0000) begin
      n_fail++;
      $display("FAIL rd_639_2: got %h want FF0000", O_PIXEL);
    end
    drive(0, 1, 0, 0, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL rd_00_again: got %h want FFFFFF", O_PIXEL);
    end
  endtask

  task automatic test_collision();
    drive(1, 1, 5, 1, 24'h00FF00);
    n_cmp++;
    if (O_PIXEL !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL collide_hold: got %h want FFFFFF", O_PIXEL);
    end
    drive(0, 1, 5, 1, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'h00FF00) begin
      n_fail++;
      $display("FAIL collide_wr: got %h want 00FF00", O_PIXEL);
    end
  endtask

  task automatic test_out_of_range();
    drive(1, 0, 0, 3, 24'h123456);
    drive(0, 1, 0, 3, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL rd_row3: got %h want 000000", O_PIXEL);
    end
    drive(0, 1, 0, 0, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL rd_00_after_row3: got %h want FFFFFF", O_PIXEL);
    end
    // Column 700 of row 0 would land on column 60 of row 1 if it aliased.
    drive(1, 0, 60, 1, 24'h0A0B0C);
    drive(1, 0, 700, 0, 24'h777777);
    drive(0, 1, 60, 1, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'h0A0B0C) begin
      n_fail++;
      $display("FAIL col_alias: got %h want 0A0B0C", O_PIXEL);
    end
    drive(0, 1, 700, 0, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL rd_col700: got %h want 000000", O_PIXEL);
    end
  endtask

  task automatic test_reset_retention();
    drive(0, 1, 639, 2, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFF0000) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want FF0000", O_PIXEL);
    end
    // Asynchronous pulse well away from any clock edge.
    #2 I_RESET = 1'b0;
    #1;
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL async_clear: got %h want 000000", O_PIXEL);
    end
    // Write attempted while reset is held must be dropped.
    drive(1, 0, 0, 0, 24'hABCDEF);
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_write: got %h want 000000", O_PIXEL);
    end
    @(negedge I_CLK);
    I_RESET = 1'b1;
    I_WRITE_ENABLE = 1'b0;
    drive(0, 1, 639, 2, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFF0000) begin
      n_fail++;
      $display("FAIL retained_639_2: got %h want FF0000", O_PIXEL);
    end
    drive(0, 1, 0, 0, 24'h0);
    n_cmp++;
    if (O_PIXEL !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL retained_00: got %h want FFFFFF", O_PIXEL);
    end
    // Reset landing while a read is pending discards that read.
    @(negedge I_CLK);
    I_READ_ENABLE = 1'b1;
    I_COLUMN = 10'd639;
    I_ROW    = 2'd2;
    #2 I_RESET = 1'b0;
    #1;
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL midop_clear: got %h want 000000", O_PIXEL);
    end
    @(posedge I_CLK); #1;
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL midop_edge: got %h want 000000", O_PIXEL);
    end
    @(negedge I_CLK);
    I_READ_ENABLE = 1'b0;
    I_RESET = 1'b1;
    mdl_out = '0;
    @(posedge I_CLK); #1;
    n_cmp++;
    if (O_PIXEL !== 24'h000000) begin
      n_fail++;
      $display("FAIL midop_release: got %h want 000000", O_PIXEL);
    end
  endtask

  task automatic test_random();
    pixel_t p;
    // Clearing pass so every in-range location holds known data.
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        drive(1, 0, c, r, 24'($urandom));
      end
    end
    n_cmp++;
    if (O_PIXEL !== mdl_out) begin
      n_fail++;
      $display("FAIL clear_pass_hold: got %h want %h", O_PIXEL, mdl_out);
    end
    for (int i = 0; i < 400; i++) begin
      int sel, col, row;
      bit we, re;
      sel = int'($urandom_range(0, 9));
      col = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023))
                                        : int'($urandom_range(0, 639));
      row = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      we  = (sel < 4) || (sel >= 8);
      re  = (sel >= 4);
      drive(we, re, col, row, 24'($urandom));
      n_cmp++;
      if (O_PIXEL !== mdl_out) begin
        n_fail++;
        p = to_pixel(mdl_out);
        $display("FAIL rand%0d (we=%0b re=%0b c=%0d r=%0d): got %h want %h (r=%h g=%h b=%h)",
                 i, we, re, col, row, O_PIXEL, mdl_out, p.r, p.g, p.b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_corners();
    test_collision();
    test_out_of_range();
    test_reset_retention();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
Synchronous single-port pixel store holding P_ROWS lines of P_COLUMNS pixels each, addressed by (column, row). It sits in the colorspace stage as a line buffer feeding downstream edge-detection windows. Writes and reads are clocked; the read result is registered onto O_PIXEL.

Parameters:
P_COLUMNS, 640, pixels per row.
P_ROWS, 3, number of stored rows.
P_PIXEL_DEPTH, 24, bits per pixel as R[23:16], G[15:8], B[7:0]; must be a multiple of 3.

Ports:
I_CLK  input  1  system clock; all state changes on the rising edge.
I_RESET  input  1  asynchronous, active-low reset.
I_COLUMN  input  $clog2(P_COLUMNS)  column address, 0 to P_COLUMNS-1.
I_ROW  input  $clog2(P_ROWS)  row address, 0 to P_ROWS-1.
I_PIXEL  input  P_PIXEL_DEPTH  write data.
I_WRITE_ENABLE  input  1  write strobe, active high.
I_READ_ENABLE  input  1  read strobe, active high.
O_PIXEL  output  P_PIXEL_DEPTH  registered read data.

Behaviour:
- Storage: P_ROWS*P_COLUMNS words of P_PIXEL_DEPTH bits. Linear index = I_ROW*P_COLUMNS + I_COLUMN.
- Reset: I_RESET low asynchronously forces O_PIXEL to 0. It stays 0 while reset is held. Memory contents are not cleared and survive reset.
- Write: on a rising edge with I_WRITE_ENABLE=1 and an in-range address, mem[row][col] <= I_PIXEL. Writes are ignored during reset.
- Read: on a rising edge with I_READ_ENABLE=1 and I_WRITE_ENABLE=0, O_PIXEL <= mem[row][col]. Latency is one clock: data is valid after the edge that samples the enable.
- O_PIXEL holds its last value when I_READ_ENABLE=0.
- Simultaneous read and write: the write has priority. The write is performed, the read is ignored, and O_PIXEL holds.
- Out-of-range address (I_COLUMN >= P_COLUMNS or I_ROW >= P_ROWS, e.g. row 3 with a 2-bit field):
  - writes are dropped with no alias into other locations;
  - reads load O_PIXEL with 0.
- A location that has never been written reads back undefined data. The bench reads only written locations or after a clearing pass.
- No handshakes and no back-pressure. One operation per cycle, back-to-back allowed.
- Reset asserted mid-operation: the in-flight read result is discarded and O_PIXEL is 0. After release, the first read returns stored data, including data written before the reset.

Decomposition:
- Shared package colorspace_pkg: default constants (640, 3, 24), subpixel depth P_PIXEL_DEPTH/3, and a packed pixel struct {r,g,b} for benches and neighbours.
- One sub-module, frame_buffer_ram, a parameterised word array with one write port and one synchronous read port. The top level handles address range checking, linear address formation, write/read priority, and the reset-clearable O_PIXEL register. This keeps the storage swappable for an SRAM macro.

Test Plan:
1. Hold I_RESET low for 2 cycles -> O_PIXEL = 0x000000 throughout. Release, no enables -> O_PIXEL stays 0.
2. Write (0,0) = 0xFFFFFF, then read (0,0) -> O_PIXEL = 0xFFFFFF one edge after the read enable is sampled. O_PIXEL unchanged during the write cycle.
3. Write (639,2) = 0xFF0000, then read (639,2) -> 0xFF0000. Re-read (0,0) -> still 0xFFFFFF (no aliasing between corners).
4. Assert write (5,1)=0x00FF00 and read together -> the write takes effect and O_PIXEL holds its previous value. The next read of (5,1) -> 0x00FF00.
5. Write row 3 column 0 = 0x123456, then read (0,3) -> O_PIXEL = 0. Read (0,0) -> 0xFFFFFF unchanged.
6. Pulse reset while O_PIXEL=0xFF0000 -> O_PIXEL goes to 0 immediately, without waiting for a clock edge. After release, read (639,2) -> 0xFF0000 (memory retained).
